// File: rtl/lcsdr_tune_pkg.sv
// Shared constants for the encoder tuning controller: step table and FSM encoding.
package lcsdr_tune_pkg;

    // Number of selectable tuning steps
    localparam int NSTEP = 6;

    // FSM state encoding (exported on state_dbg)
    localparam logic [1:0] ST_PUSH_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_CALC      = 2'd2;
    localparam logic [1:0] ST_PUSH      = 2'd3;

    // Step size in frequency-word units for a given step index
    function automatic logic [31:0] step_val(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'd1;
            3'd1:    v = 32'd10;
            3'd2:    v = 32'd100;
            3'd3:    v = 32'd1000;
            3'd4:    v = 32'd10000;
            3'd5:    v = 32'd100000;
            default: v = 32'd1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tune_accel_win.sv
// Detent-speed detector: a detent arriving within ACC_WIN cycles of the
// previous one is flagged as accelerated. The counter resets to ACC_WIN so
// the very first detent after reset is never accelerated.
module tune_accel_win #(
    parameter int ACC_WIN = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_cnt,
    output logic accel
);

    localparam int CW = $clog2(ACC_WIN + 1);
    localparam logic [CW-1:0] WIN_MAX = CW'(ACC_WIN);

    logic [CW-1:0] win_cnt;

    // Cycles since the last detent, saturating; accel latched on each detent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= WIN_MAX;
            accel   <= 1'b0;
        end else if (enc_cnt) begin
            win_cnt <= '0;
            accel   <= (win_cnt < WIN_MAX);
        end else if (win_cnt != WIN_MAX) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/enc_tune_ctrl.sv
// Encoder tuning controller: detents accumulate in a signed pending counter,
// CALC applies them one per cycle to a saturating working word, and each
// changed word is offered to the NCO.
//
// Handshake: upd_valid rises with a new freq_word; freq_word is held stable
// while upd_valid=1; the transfer happens on a rising clk edge where
// upd_valid & upd_ready are both 1, after which upd_valid drops.
module enc_tune_ctrl
    import lcsdr_tune_pkg::*;
#(
    parameter int              FW      = 32,
    parameter logic [FW-1:0]   F_MIN   = '0,
    parameter logic [FW-1:0]   F_MAX   = '1,
    parameter logic [FW-1:0]   F_INIT  = '0,
    parameter int              ACC_WIN = 500000,
    parameter int              ACC_SH  = 2,
    parameter int              PEND_W  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enc_cnt,
    input  logic          enc_dir,
    input  logic          enc_sw,
    output logic [FW-1:0] freq_word,
    output logic [2:0]    step_idx,
    output logic          accel,
    output logic          upd_valid,
    input  logic          upd_ready,
    output logic [1:0]    state_dbg
);

    localparam int PW = PEND_W + 2;
    localparam logic signed [PW-1:0] P_ONE    = PW'(1);
    localparam logic signed [PW-1:0] M_ONE    = PW'(-1);
    localparam logic signed [PW-1:0] PEND_LIM = PW'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [PW-1:0] PEND_NEG = PW'(1 - (1 << (PEND_W - 1)));
    localparam logic [2:0] STEP_LAST = 3'(NSTEP - 1);

    logic [1:0]               state;
    logic [FW-1:0]            work;
    logic signed [PEND_W-1:0] pending;
    logic signed [PEND_W-1:0] pend_nxt;
    logic signed [PW-1:0]     cap_d, con_d, pend_sum;
    logic                     calc_step, step_up;
    logic [FW:0]              base, eff, sum_up, sum_dn;
    logic [FW-1:0]            work_step, work_nxt;

    assign state_dbg = state;
    assign calc_step = (state == ST_CALC) && (pending != '0);
    assign step_up   = !pending[PEND_W-1];

    tune_accel_win #(
        .ACC_WIN (ACC_WIN)
    ) u_accel (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_cnt (enc_cnt),
        .accel   (accel)
    );

    // Pending counter: capture and CALC consumption net together, then saturate
    always_comb begin
        cap_d = '0;
        if (enc_cnt) cap_d = enc_dir ? P_ONE : M_ONE;
        con_d = '0;
        if (calc_step) con_d = step_up ? M_ONE : P_ONE;
        pend_sum = $signed({{2{pending[PEND_W-1]}}, pending}) + cap_d + con_d;
        pend_nxt = pend_sum[PEND_W-1:0];
        if (pend_sum > PEND_LIM) pend_nxt = PEND_LIM[PEND_W-1:0];
        else if (pend_sum < PEND_NEG) pend_nxt = PEND_NEG[PEND_W-1:0];
    end

    // One-detent step of the working word, clamped to [F_MIN, F_MAX]
    always_comb begin
        base   = (FW+1)'(step_val(step_idx));
        eff    = accel ? (base << ACC_SH) : base;
        sum_up = {1'b0, work} + eff;
        sum_dn = {1'b0, work} - eff;
        if (step_up) begin
            work_step = (sum_up > {1'b0, F_MAX}) ? F_MAX : sum_up[FW-1:0];
        end else begin
            work_step = (sum_dn[FW] || (sum_dn[FW-1:0] < F_MIN)) ? F_MIN : sum_dn[FW-1:0];
        end
        work_nxt = calc_step ? work_step : work;
    end

    // Control FSM, step selection and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PUSH_INIT;
            freq_word <= F_INIT;
            work      <= F_INIT;
            step_idx  <= '0;
            upd_valid <= 1'b0;
            pending   <= '0;
        end else begin
            pending <= pend_nxt;
            work    <= work_nxt;
            if (enc_sw) step_idx <= (step_idx == STEP_LAST) ? 3'd0 : step_idx + 3'd1;
            case (state)
                ST_PUSH_INIT: begin
                    upd_valid <= 1'b1;
                    state     <= ST_PUSH;
                end
                ST_IDLE: begin
                    if (pending != '0) state <= ST_CALC;
                end
                ST_CALC: begin
                    if (pend_nxt == '0) begin
                        if (work_nxt != freq_word) begin
                            freq_word <= work_nxt;
                            upd_valid <= 1'b1;
                            state     <= ST_PUSH;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PUSH: begin
                    if (upd_ready) begin
                        upd_valid <= 1'b0;
                        state     <= (pending != '0) ? ST_CALC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
